// File: rtl/cd_sram_arbiter_pkg.sv
// Shared types and defaults for the Color/Depth SRAM arbiter.
// Includes the FSM state encoding, the read-return owner tag and the word geometry.
package cd_sram_arbiter_pkg;

  localparam int ADDR_W_DEF  = 16;
  localparam int COLOR_W_DEF = 384;
  localparam int DEPTH_W_DEF = 336;
  localparam int PIX_N       = 16;
  localparam int RGB_W       = 24;

  localparam logic [DEPTH_W_DEF-1:0] DEPTH_FAR = '1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  typedef enum logic {
    OWN_RAST = 1'b0,
    OWN_SCAN = 1'b1
  } owner_e;

endpackage

// File: rtl/cd_sram_arbiter_if.sv
// Single-port CD SRAM bus: the arbiter (master) issues registered commands,
// the SRAM (slave) returns read data one cycle after a read command.
interface cd_sram_arbiter_if #(
  parameter int ADDR_W  = 16,
  parameter int COLOR_W = 384,
  parameter int DEPTH_W = 336
);
  logic               sram_en;
  logic               sram_we;
  logic [ADDR_W-1:0]  sram_addr;
  logic [15:0]        sram_wmask;
  logic [COLOR_W-1:0] sram_wcolor;
  logic [DEPTH_W-1:0] sram_wdepth;
  logic [COLOR_W-1:0] sram_rcolor;
  logic [DEPTH_W-1:0] sram_rdepth;

  modport master (
    output sram_en, sram_we, sram_addr, sram_wmask, sram_wcolor, sram_wdepth,
    input  sram_rcolor, sram_rdepth
  );

  modport slave (
    input  sram_en, sram_we, sram_addr, sram_wmask, sram_wcolor, sram_wdepth,
    output sram_rcolor, sram_rdepth
  );
endinterface

// File: rtl/cd_sram_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter: on contention the requester that was not
// granted last wins; the last-grant pointer starts at the scan-out side.
module rr_arb2
  import cd_sram_arbiter_pkg::*;
(
  input  logic clk,
  input  logic srst_n,
  input  logic en,
  input  logic req_rast,
  input  logic req_scan,
  output logic gnt_rast,
  output logic gnt_scan
);

  owner_e last_q, last_d;

  always_comb begin
    gnt_rast = 1'b0;
    gnt_scan = 1'b0;
    last_d   = last_q;
    if (en) begin
      if (req_rast && req_scan) begin
        if (last_q == OWN_SCAN) gnt_rast = 1'b1;
        else                    gnt_scan = 1'b1;
      end else if (req_rast) begin
        gnt_rast = 1'b1;
      end else if (req_scan) begin
        gnt_scan = 1'b1;
      end
    end
    if (gnt_rast) last_d = OWN_RAST;
    if (gnt_scan) last_d = OWN_SCAN;
  end

  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) last_q <= OWN_SCAN;
    else         last_q <= last_d;
  end

endmodule

// File: rtl/cd_sram_arbiter.sv
// Owns the CD SRAM port: arbitrates rasterizer and scan-out accesses and runs the
// frame-clear sweep that writes background color and far depth to every word.
module cd_sram_arbiter
  import cd_sram_arbiter_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int NUM_WORDS      = 65536,
  parameter int COLOR_W        = COLOR_W_DEF,
  parameter int DEPTH_W        = DEPTH_W_DEF,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic               clk,
  input  logic               srst_n,
  input  logic               clear_start,
  input  logic [RGB_W-1:0]   clear_color,
  output logic               clear_busy,
  output logic               clear_done,
  input  logic               rast_req,
  input  logic               rast_we,
  input  logic [ADDR_W-1:0]  rast_addr,
  input  logic [COLOR_W-1:0] rast_wcolor,
  input  logic [DEPTH_W-1:0] rast_wdepth,
  input  logic [15:0]        rast_wmask,
  output logic               rast_gnt,
  output logic               rast_rvalid,
  input  logic               scan_req,
  input  logic [ADDR_W-1:0]  scan_addr,
  output logic               scan_gnt,
  output logic               scan_rvalid,
  output logic [COLOR_W-1:0] rd_color,
  output logic [DEPTH_W-1:0] rd_depth,
  cd_sram_arbiter_if.master  sram
);

  localparam int               CNT_W    = ADDR_W + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_WORDS - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic               en_q, en_d, we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [15:0]        wmask_q, wmask_d;
  logic [COLOR_W-1:0] wcolor_q, wcolor_d;
  logic [DEPTH_W-1:0] wdepth_q, wdepth_d;
  logic               rd_vld_p1_q, rd_vld_p1_d;
  owner_e             rd_own_p1_q, rd_own_p1_d;
  logic               rast_rvalid_q, rast_rvalid_d, scan_rvalid_q, scan_rvalid_d;
  logic               grant_en;

  // Reset is folded into the enable so no grant can leak out while it is held.
  assign grant_en = srst_n && (state_q == ST_IDLE) && !clear_start;

  rr_arb2 u_arb (
    .clk      (clk),
    .srst_n   (srst_n),
    .en       (grant_en),
    .req_rast (rast_req),
    .req_scan (scan_req),
    .gnt_rast (rast_gnt),
    .gnt_scan (scan_gnt)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    en_d        = 1'b0;
    we_d        = 1'b0;
    addr_d      = addr_q;
    wmask_d     = wmask_q;
    wcolor_d    = wcolor_q;
    wdepth_d    = wdepth_q;
    rd_vld_p1_d = 1'b0;
    rd_own_p1_d = rd_own_p1_q;
    unique case (state_q)
      ST_IDLE: begin
        if (clear_start) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end else if (rast_gnt) begin
          en_d   = 1'b1;
          we_d   = rast_we;
          addr_d = rast_addr;
          if (rast_we) begin
            wmask_d  = rast_wmask;
            wcolor_d = rast_wcolor;
            wdepth_d = rast_wdepth;
          end else begin
            rd_vld_p1_d = 1'b1;
            rd_own_p1_d = OWN_RAST;
          end
        end else if (scan_gnt) begin
          en_d        = 1'b1;
          addr_d      = scan_addr;
          rd_vld_p1_d = 1'b1;
          rd_own_p1_d = OWN_SCAN;
        end
      end
      ST_CLEAR: begin
        en_d     = 1'b1;
        we_d     = 1'b1;
        addr_d   = cnt_q[ADDR_W-1:0];
        wmask_d  = 16'hFFFF;
        wcolor_d = COLOR_W'({PIX_N{clear_color}});
        wdepth_d = '1;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d        = (state_d == ST_CLEAR);
    rast_rvalid_d = rd_vld_p1_q && (rd_own_p1_q == OWN_RAST);
    scan_rvalid_d = rd_vld_p1_q && (rd_own_p1_q == OWN_SCAN);
  end

  // Stage p1: command on sram_*; stage p2: read data returned to its owner.
  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      state_q       <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
      cnt_q         <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      en_q          <= 1'b0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wmask_q       <= '0;
      wcolor_q      <= '0;
      wdepth_q      <= '0;
      rd_vld_p1_q   <= 1'b0;
      rd_own_p1_q   <= OWN_RAST;
      rast_rvalid_q <= 1'b0;
      scan_rvalid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      en_q          <= en_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      wmask_q       <= wmask_d;
      wcolor_q      <= wcolor_d;
      wdepth_q      <= wdepth_d;
      rd_vld_p1_q   <= rd_vld_p1_d;
      rd_own_p1_q   <= rd_own_p1_d;
      rast_rvalid_q <= rast_rvalid_d;
      scan_rvalid_q <= scan_rvalid_d;
    end
  end

  assign clear_busy       = busy_q;
  assign clear_done       = done_q;
  assign rast_rvalid      = rast_rvalid_q;
  assign scan_rvalid      = scan_rvalid_q;
  assign rd_color         = sram.sram_rcolor;
  assign rd_depth         = sram.sram_rdepth;
  assign sram.sram_en     = en_q;
  assign sram.sram_we     = we_q;
  assign sram.sram_addr   = addr_q;
  assign sram.sram_wmask  = wmask_q;
  assign sram.sram_wcolor = wcolor_q;
  assign sram.sram_wdepth = wdepth_q;

endmodule

// File: tb/tb_cd_sram_arbiter.sv
// Bench for cd_sram_arbiter: directed tables and sequences, then random traffic
// against a transaction-level reference of memory contents, grants and read returns.
module tb_cd_sram_arbiter;
  import cd_sram_arbiter_pkg::*;

  localparam int AW = 4;
  localparam int CW = 384;
  localparam int DW = 336;
  localparam int NW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          srst_n, clear_start, mem_load;
  logic [23:0]   clear_color;
  logic          rast_req, rast_we, scan_req;
  logic [AW-1:0] rast_addr, scan_addr;
  logic [CW-1:0] rast_wcolor;
  logic [DW-1:0] rast_wdepth;
  logic [15:0]   rast_wmask;

  logic          clear_busy, clear_done, rast_gnt, rast_rvalid, scan_gnt, scan_rvalid;
  logic [CW-1:0] rd_color;
  logic [DW-1:0] rd_depth;
  logic          c_clear_busy, c_clear_done, c_rast_gnt, c_rast_rvalid, c_scan_gnt, c_scan_rvalid;
  logic [CW-1:0] c_rd_color;
  logic [DW-1:0] c_rd_depth;

  cd_sram_arbiter_if #(.ADDR_W(AW), .COLOR_W(CW), .DEPTH_W(DW)) sif ();
  cd_sram_arbiter_if #(.ADDR_W(AW), .COLOR_W(CW), .DEPTH_W(DW)) cif ();

  cd_sram_arbiter #(.ADDR_W(AW), .NUM_WORDS(NW), .COLOR_W(CW), .DEPTH_W(DW), .CLEAR_ON_RESET(1'b0)) dut (
    .clk(clk), .srst_n(srst_n), .clear_start(clear_start), .clear_color(clear_color),
    .clear_busy(clear_busy), .clear_done(clear_done),
    .rast_req(rast_req), .rast_we(rast_we), .rast_addr(rast_addr), .rast_wcolor(rast_wcolor),
    .rast_wdepth(rast_wdepth), .rast_wmask(rast_wmask), .rast_gnt(rast_gnt), .rast_rvalid(rast_rvalid),
    .scan_req(scan_req), .scan_addr(scan_addr), .scan_gnt(scan_gnt), .scan_rvalid(scan_rvalid),
    .rd_color(rd_color), .rd_depth(rd_depth), .sram(sif));

  cd_sram_arbiter #(.ADDR_W(AW), .NUM_WORDS(NW), .COLOR_W(CW), .DEPTH_W(DW), .CLEAR_ON_RESET(1'b1)) dut_cor (
    .clk(clk), .srst_n(srst_n), .clear_start(1'b0), .clear_color(clear_color),
    .clear_busy(c_clear_busy), .clear_done(c_clear_done),
    .rast_req(rast_req), .rast_we(1'b0), .rast_addr(rast_addr), .rast_wcolor(rast_wcolor),
    .rast_wdepth(rast_wdepth), .rast_wmask(rast_wmask), .rast_gnt(c_rast_gnt), .rast_rvalid(c_rast_rvalid),
    .scan_req(scan_req), .scan_addr(scan_addr), .scan_gnt(c_scan_gnt), .scan_rvalid(c_scan_rvalid),
    .rd_color(c_rd_color), .rd_depth(c_rd_depth), .sram(cif));

  assign cif.sram_rcolor = '0;
  assign cif.sram_rdepth = '0;

  function automatic logic [CW-1:0] pat_c(input int i);
    return {12{(32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000}};
  endfunction

  function automatic logic [DW-1:0] pat_d(input int i);
    return {21{16'(i * 16'h1357 + 16'h0F0F)}};
  endfunction

  // Behavioural SRAM: per-pixel masked writes, registered read data.
  logic [CW-1:0] mem_c [16];
  logic [DW-1:0] mem_d [16];
  logic [CW-1:0] rcol;
  logic [DW-1:0] rdep;
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 16; i++) begin
        mem_c[i] <= pat_c(i);
        mem_d[i] <= pat_d(i);
      end
    end else if (sif.sram_en) begin
      if (sif.sram_we) begin
        for (int p = 0; p < 16; p++)
          if (sif.sram_wmask[p]) begin
            mem_c[sif.sram_addr][p*24 +: 24] <= sif.sram_wcolor[p*24 +: 24];
            mem_d[sif.sram_addr][p*21 +: 21] <= sif.sram_wdepth[p*21 +: 21];
          end
      end else begin
        rcol <= mem_c[sif.sram_addr];
        rdep <= mem_d[sif.sram_addr];
      end
    end
  end
  assign sif.sram_rcolor = rcol;
  assign sif.sram_rdepth = rdep;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    srst_n = 1'b0; rast_req = 1'b0; scan_req = 1'b0; clear_start = 1'b0; mem_load = 1'b1;
    @(negedge clk);
    mem_load = 1'b0;
    @(negedge clk);
    srst_n = 1'b1;
  endtask

  function automatic logic [CW-1:0] rnd_c();
    logic [CW-1:0] v;
    for (int i = 0; i < 12; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  typedef struct {
    logic rq, sq;
    logic exp_rg, exp_sg, exp_rvr, exp_rvs;
  } vec_t;

  typedef struct {
    bit            own;
    logic [CW-1:0] col;
    logic [DW-1:0] dep;
    int            due;
  } rd_t;

  vec_t          tbl [11];
  rd_t           rq_q [$];
  logic [CW-1:0] ref_c [16];
  logic [DW-1:0] ref_d [16];

  initial begin
    int k, dones, busy_cnt, done_at, clear_t, clear_end;
    bit found, m_last, idle, e_rg, e_sg, e_rvr, e_rvs;
    logic [CW-1:0] wc, ec;
    logic [DW-1:0] wd, ed;
    rd_t r;

    tbl[0]  = '{1, 1, 1, 0, 0, 0};
    tbl[1]  = '{1, 1, 0, 1, 0, 0};
    tbl[2]  = '{1, 1, 1, 0, 1, 0};
    tbl[3]  = '{1, 1, 0, 1, 0, 1};
    tbl[4]  = '{0, 0, 0, 0, 1, 0};
    tbl[5]  = '{0, 1, 0, 1, 0, 1};
    tbl[6]  = '{1, 0, 1, 0, 0, 0};
    tbl[7]  = '{1, 0, 1, 0, 0, 1};
    tbl[8]  = '{1, 1, 0, 1, 1, 0};
    tbl[9]  = '{0, 1, 0, 1, 1, 0};
    tbl[10] = '{1, 1, 1, 0, 0, 1};

    srst_n = 1'b0; clear_start = 1'b0; mem_load = 1'b1; clear_color = 24'hA5C3E1;
    rast_req = 1'b1; scan_req = 1'b1; rast_we = 1'b0; rast_addr = '0; scan_addr = '0;
    rast_wcolor = '0; rast_wdepth = '0; rast_wmask = '0;
    repeat (2) @(negedge clk);
    mem_load = 1'b0;
    #1;
    chk("rst_busy", clear_busy, 0);
    chk("rst_done", clear_done, 0);
    chk("rst_rgnt", rast_gnt, 0);
    chk("rst_sgnt", scan_gnt, 0);
    chk("rst_en", sif.sram_en, 0);
    chk("rst_addr", sif.sram_addr, 0);
    chk("rst_rvalid", rast_rvalid | scan_rvalid, 0);
    chk("rst_cor_busy", c_clear_busy, 0);
    chk("rst_cor_gnt", c_rast_gnt | c_scan_gnt, 0);
    chk("rst_cor_en", cif.sram_en, 0);

    // Clear-on-reset sweep with both requesters held.
    @(negedge clk);
    srst_n = 1'b1;
    k = 0; dones = 0;
    for (int c = 0; c < 20; c++) begin
      if (cif.sram_en && dones == 0) begin
        chk("t1_we", cif.sram_we, 1);
        chk("t1_addr", cif.sram_addr, k);
        chk("t1_wmask", cif.sram_wmask, 16'hFFFF);
        chk("t1_wdepth", cif.sram_wdepth, {DW{1'b1}});
        chk("t1_wcolor", cif.sram_wcolor, {16{clear_color}});
        k++;
      end
      if (c_clear_done) begin
        dones++;
        #1 chk("t1_gnt_resume", c_rast_gnt, 1);
      end else if (dones == 0) begin
        #1 chk("t1_no_gnt", c_rast_gnt | c_scan_gnt, 0);
      end
      @(negedge clk);
    end
    chk("t1_nwrites", k, NW);
    chk("t1_ndone", dones, 1);

    // Grant/return table from a fresh reset, all reads.
    do_reset();
    for (int i = 0; i < 11; i++) begin
      chk("tbl_rvr", rast_rvalid, tbl[i].exp_rvr);
      chk("tbl_rvs", scan_rvalid, tbl[i].exp_rvs);
      if (tbl[i].exp_rvr) chk("tbl_rcol", rd_color, pat_c(i - 2));
      if (tbl[i].exp_rvs) chk("tbl_scol", rd_color, pat_c(15 - (i - 2)));
      rast_req = tbl[i].rq; scan_req = tbl[i].sq; rast_we = 1'b0;
      rast_addr = AW'(i); scan_addr = AW'(15 - i);
      #1;
      chk("tbl_rgnt", rast_gnt, tbl[i].exp_rg);
      chk("tbl_sgnt", scan_gnt, tbl[i].exp_sg);
      @(negedge clk);
    end
    rast_req = 1'b0; scan_req = 1'b0;
    repeat (3) @(negedge clk);

    // Single rasterizer read of word 5.
    rast_req = 1'b1; rast_we = 1'b0; rast_addr = 4'd5;
    #1;
    chk("t2_rgnt", rast_gnt, 1);
    chk("t2_sgnt", scan_gnt, 0);
    @(negedge clk);
    rast_req = 1'b0;
    chk("t2_en", sif.sram_en, 1);
    chk("t2_we", sif.sram_we, 0);
    chk("t2_addr", sif.sram_addr, 5);
    @(negedge clk);
    chk("t2_rvalid", rast_rvalid, 1);
    chk("t2_svalid", scan_rvalid, 0);
    chk("t2_color", rd_color, pat_c(5));
    chk("t2_depth", rd_depth, pat_d(5));

    // Masked write of pixel 0 at word 2, then scan-out read back.
    wc = rnd_c(); wd = DW'(rnd_c());
    rast_req = 1'b1; rast_we = 1'b1; rast_addr = 4'd2; rast_wmask = 16'h0001;
    rast_wcolor = wc; rast_wdepth = wd;
    #1 chk("t6_wgnt", rast_gnt, 1);
    @(negedge clk);
    rast_req = 1'b0; rast_we = 1'b0; scan_req = 1'b1; scan_addr = 4'd2;
    #1 chk("t6_sgnt", scan_gnt, 1);
    @(negedge clk);
    scan_req = 1'b0;
    @(negedge clk);
    ec = pat_c(2); ec[23:0] = wc[23:0];
    ed = pat_d(2); ed[20:0] = wd[20:0];
    chk("t6_svalid", scan_rvalid, 1);
    chk("t6_color", rd_color, ec);
    chk("t6_depth", rd_depth, ed);

    // Clear while scan-out keeps requesting.
    clear_color = 24'h13579B; scan_req = 1'b1; scan_addr = 4'd3; clear_start = 1'b1;
    #1 chk("t4_gnt_at_start", scan_gnt, 0);
    @(negedge clk);
    clear_start = 1'b0;
    busy_cnt = 0; done_at = -1;
    for (int c = 1; c <= 20; c++) begin
      if (done_at >= 0 && c == done_at + 1) scan_req = 1'b0;
      if (done_at >= 0 && c == done_at + 2) begin
        chk("t4_svalid", scan_rvalid, 1);
        chk("t4_color", rd_color, {16{24'h13579B}});
        chk("t4_depth", rd_depth, {DW{1'b1}});
      end
      if (clear_busy) busy_cnt++;
      if (clear_done && done_at < 0) begin
        done_at = c;
        #1 chk("t4_gnt_at_done", scan_gnt, 1);
      end else if (clear_busy) begin
        #1 chk("t4_no_gnt", scan_gnt, 0);
      end
      @(negedge clk);
    end
    scan_req = 1'b0;
    chk("t4_done_at", done_at, NW + 1);
    chk("t4_busy_cycles", busy_cnt, NW);

    // Reset asserted part-way through a sweep.
    clear_start = 1'b1;
    @(negedge clk);
    clear_start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (sif.sram_en && sif.sram_addr == 4'd4) found = 1'b1;
    end
    chk("t5_saw_write4", found, 1);
    rast_req = 1'b1;
    #2 srst_n = 1'b0;
    #1;
    chk("t5_en", sif.sram_en, 0);
    chk("t5_we", sif.sram_we, 0);
    chk("t5_addr", sif.sram_addr, 0);
    chk("t5_wmask", sif.sram_wmask, 0);
    chk("t5_wcolor", sif.sram_wcolor, 0);
    chk("t5_busy", clear_busy, 0);
    chk("t5_done", clear_done, 0);
    chk("t5_gnt", rast_gnt, 0);
    @(negedge clk);
    srst_n = 1'b1;
    dones = 0;
    for (int c = 0; c < 12; c++) begin
      if (clear_done) dones++;
      @(negedge clk);
    end
    chk("t5_no_done", dones, 0);
    chk("t5_idle_busy", clear_busy, 0);
    #1 chk("t5_idle_gnt", rast_gnt, 1);
    rast_req = 1'b0;

    // Random traffic against the transaction-level reference.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      ref_c[i] = pat_c(i);
      ref_d[i] = pat_d(i);
    end
    clear_t = -10; clear_end = -1; m_last = 1'b1;
    rq_q.delete();
    for (int cyc = 0; cyc < 800; cyc++) begin
      e_rvr = 1'b0; e_rvs = 1'b0;
      if (rq_q.size() > 0 && rq_q[0].due == cyc) begin
        r = rq_q.pop_front();
        if (r.own) e_rvs = 1'b1; else e_rvr = 1'b1;
        chk("rnd_color", rd_color, r.col);
        chk("rnd_depth", rd_depth, r.dep);
      end
      chk("rnd_rvr", rast_rvalid, e_rvr);
      chk("rnd_rvs", scan_rvalid, e_rvs);
      chk("rnd_busy", clear_busy, (cyc >= clear_t + 1 && cyc <= clear_end));
      chk("rnd_done", clear_done, (clear_end >= 0 && cyc == clear_end + 1));

      idle = (cyc > clear_end);
      rast_req = ($urandom_range(0, 9) < 6);
      scan_req = ($urandom_range(0, 9) < 6);
      rast_we = ($urandom_range(0, 9) < 4);
      rast_addr = AW'($urandom); scan_addr = AW'($urandom);
      rast_wmask = 16'($urandom); rast_wcolor = rnd_c(); rast_wdepth = DW'(rnd_c());
      clear_start = ($urandom_range(0, 59) == 0);
      if (idle && clear_start) clear_color = 24'($urandom);

      e_rg = 1'b0; e_sg = 1'b0;
      if (idle && !clear_start) begin
        if (rast_req && scan_req) begin
          if (m_last) e_rg = 1'b1; else e_sg = 1'b1;
        end else if (rast_req) e_rg = 1'b1;
        else if (scan_req) e_sg = 1'b1;
      end
      #1;
      chk("rnd_rgnt", rast_gnt, e_rg);
      chk("rnd_sgnt", scan_gnt, e_sg);

      if (e_rg) m_last = 1'b0;
      if (e_sg) m_last = 1'b1;
      if (e_rg && rast_we) begin
        for (int p = 0; p < 16; p++)
          if (rast_wmask[p]) begin
            ref_c[rast_addr][p*24 +: 24] = rast_wcolor[p*24 +: 24];
            ref_d[rast_addr][p*21 +: 21] = rast_wdepth[p*21 +: 21];
          end
      end else if (e_rg) begin
        rq_q.push_back('{1'b0, ref_c[rast_addr], ref_d[rast_addr], cyc + 2});
      end
      if (e_sg) rq_q.push_back('{1'b1, ref_c[scan_addr], ref_d[scan_addr], cyc + 2});
      if (idle && clear_start) begin
        clear_t = cyc;
        clear_end = cyc + NW;
        for (int i = 0; i < NW; i++) begin
          ref_c[i] = {16{clear_color}};
          ref_d[i] = '1;
        end
      end
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
